// File: rtl/enemy_spawn_scheduler.sv
// Enemy life-cycle controller: per-enemy ACTIVE/BOOM/WAIT/READY tracking,
// one round-robin respawn grant per frame over three fixed spawn points,
// and a saturating kill counter.
module enemy_spawn_scheduler #(
  parameter int unsigned NUM_ENEMY      = 2,
  parameter int unsigned BOOM_FRAMES    = 8,
  parameter int unsigned RESPAWN_FRAMES = 60,
  parameter int unsigned SPAWN_X0       = 32,
  parameter int unsigned SPAWN_X1       = 192,
  parameter int unsigned SPAWN_X2       = 352,
  parameter int unsigned SPAWN_Y        = 32
) (
  input  logic                      clk_50MHz,
  input  logic                      reset,
  input  logic                      refresh_tick,
  input  logic [NUM_ENEMY-1:0]      enemy_hit,
  input  logic [10*NUM_ENEMY-1:0]   enemy_x,
  input  logic [10*NUM_ENEMY-1:0]   enemy_y,
  input  logic [9:0]                x_tank,
  input  logic [9:0]                y_tank,
  output logic [NUM_ENEMY-1:0]      enemy_active,
  output logic [NUM_ENEMY-1:0]      enemy_boom,
  output logic                      spawn_valid,
  output logic [2:0]                spawn_id,
  output logic [9:0]                spawn_x,
  output logic [9:0]                spawn_y,
  output logic [7:0]                kill_count
);

  typedef enum logic [1:0] {StActive, StBoom, StWait, StReady} state_e;

  localparam int          NE        = int'(NUM_ENEMY);
  localparam logic [9:0]  SPAWN_Y_W = 10'(SPAWN_Y);

  state_e                r_state [NUM_ENEMY];
  logic [7:0]            r_cnt   [NUM_ENEMY];
  logic [2:0]            r_en_ptr;
  logic [1:0]            r_sp_ptr;
  logic [NUM_ENEMY-1:0]  r_active;
  logic [NUM_ENEMY-1:0]  r_boom;
  logic                  r_spawn_valid;
  logic [2:0]            r_spawn_id;
  logic [9:0]            r_spawn_x;
  logic [9:0]            r_spawn_y;
  logic [7:0]            r_kill;

  logic [2:0]            w_blocked;
  logic                  w_pt_found;
  logic [1:0]            w_pt_idx;
  logic                  w_en_found;
  logic [2:0]            w_en_idx;
  logic                  w_grant;
  logic [3:0]            w_kill_pop;
  logic [8:0]            w_kill_sum;
  logic [7:0]            w_kill_next;
  int                    w_pt_v;
  int                    w_en_v;

  function automatic logic [9:0] f_spawn_x(input logic [1:0] p);
    case (p)
      2'd0:    return 10'(SPAWN_X0);
      2'd1:    return 10'(SPAWN_X1);
      default: return 10'(SPAWN_X2);
    endcase
  endfunction

  // 32x32 box overlap, widened to 11 bits so the +32 never wraps
  function automatic logic f_overlap(input logic [9:0] ax, input logic [9:0] ay,
                                     input logic [9:0] bx, input logic [9:0] by);
    logic [10:0] axw, ayw, bxw, byw;
    axw = {1'b0, ax};
    ayw = {1'b0, ay};
    bxw = {1'b0, bx};
    byw = {1'b0, by};
    return (axw < bxw + 11'd32) && (bxw < axw + 11'd32) &&
           (ayw < byw + 11'd32) && (byw < ayw + 11'd32);
  endfunction

  // A spawn point is blocked by the tank or by any enemy active before this tick
  always_comb begin
    w_blocked = '0;
    for (int p = 0; p < 3; p++) begin
      w_blocked[p] = f_overlap(f_spawn_x(2'(p)), SPAWN_Y_W, x_tank, y_tank);
      for (int i = 0; i < NE; i++) begin
        if (r_state[i] == StActive &&
            f_overlap(f_spawn_x(2'(p)), SPAWN_Y_W, enemy_x[10*i +: 10], enemy_y[10*i +: 10])) begin
          w_blocked[p] = 1'b1;
        end
      end
    end
  end

  // First unblocked spawn point from r_sp_ptr, wrapping at 3
  always_comb begin
    w_pt_found = 1'b0;
    w_pt_idx   = '0;
    w_pt_v     = 0;
    for (int k = 0; k < 3; k++) begin
      w_pt_v = int'(r_sp_ptr) + k;
      if (w_pt_v >= 3) w_pt_v = w_pt_v - 3;
      if (!w_pt_found && !w_blocked[w_pt_v]) begin
        w_pt_found = 1'b1;
        w_pt_idx   = 2'(w_pt_v);
      end
    end
  end

  // First READY enemy from r_en_ptr, wrapping at NUM_ENEMY
  always_comb begin
    w_en_found = 1'b0;
    w_en_idx   = '0;
    w_en_v     = 0;
    for (int k = 0; k < NE; k++) begin
      w_en_v = int'(r_en_ptr) + k;
      if (w_en_v >= NE) w_en_v = w_en_v - NE;
      if (!w_en_found && r_state[w_en_v] == StReady) begin
        w_en_found = 1'b1;
        w_en_idx   = 3'(w_en_v);
      end
    end
  end

  // Kills this tick: only enemies that were ACTIVE count; sum saturates at 255
  always_comb begin
    w_kill_pop = '0;
    for (int i = 0; i < NE; i++) begin
      if (r_state[i] == StActive && enemy_hit[i]) w_kill_pop = w_kill_pop + 4'd1;
    end
    w_kill_sum  = {1'b0, r_kill} + 9'(w_kill_pop);
    w_kill_next = w_kill_sum[8] ? 8'hFF : w_kill_sum[7:0];
    w_grant     = refresh_tick && w_en_found && w_pt_found;
  end

  // Enemy FSMs, arbitration pointers, grant registers and registered decodes
  always_ff @(posedge clk_50MHz) begin
    if (!reset) begin
      for (int i = 0; i < NE; i++) begin
        r_state[i] <= StReady;
        r_cnt[i]   <= '0;
      end
      r_en_ptr      <= '0;
      r_sp_ptr      <= '0;
      r_active      <= '0;
      r_boom        <= '0;
      r_spawn_valid <= 1'b0;
      r_spawn_id    <= '0;
      r_spawn_x     <= 10'(SPAWN_X0);
      r_spawn_y     <= SPAWN_Y_W;
      r_kill        <= '0;
    end else begin
      r_spawn_valid <= w_grant;
      for (int i = 0; i < NE; i++) begin
        r_active[i] <= (r_state[i] == StActive);
        r_boom[i]   <= (r_state[i] == StBoom);
      end
      if (refresh_tick) begin
        for (int i = 0; i < NE; i++) begin
          unique case (r_state[i])
            StActive: begin
              if (enemy_hit[i]) begin
                r_state[i] <= StBoom;
                r_cnt[i]   <= 8'(BOOM_FRAMES - 1);
              end
            end
            StBoom: begin
              if (r_cnt[i] == 8'd0) begin
                r_state[i] <= StWait;
                r_cnt[i]   <= 8'(RESPAWN_FRAMES - 1);
              end else begin
                r_cnt[i] <= r_cnt[i] - 8'd1;
              end
            end
            StWait: begin
              if (r_cnt[i] == 8'd0) r_state[i] <= StReady;
              else                  r_cnt[i]   <= r_cnt[i] - 8'd1;
            end
            StReady: begin
              if (w_grant && w_en_idx == 3'(i)) r_state[i] <= StActive;
            end
          endcase
        end
        r_kill <= w_kill_next;
        if (w_grant) begin
          r_en_ptr   <= ({1'b0, w_en_idx} + 4'd1 == 4'(NUM_ENEMY)) ? 3'd0 : w_en_idx + 3'd1;
          r_sp_ptr   <= (w_pt_idx == 2'd2) ? 2'd0 : w_pt_idx + 2'd1;
          r_spawn_id <= w_en_idx;
          r_spawn_x  <= f_spawn_x(w_pt_idx);
          r_spawn_y  <= SPAWN_Y_W;
        end
      end
    end
  end

  assign enemy_active = r_active;
  assign enemy_boom   = r_boom;
  assign spawn_valid  = r_spawn_valid;
  assign spawn_id     = r_spawn_id;
  assign spawn_x      = r_spawn_x;
  assign spawn_y      = r_spawn_y;
  assign kill_count   = r_kill;

endmodule
